// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type, counter sizing and zero-divisor result constants
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  localparam logic DBZ_QUOT_BIT = 1'b1;
  localparam logic DBZ_FLAG     = 1'b1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration producing the next partial remainder and quotient bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             d_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_o
);
  logic [WIDTH:0] p, s;
  assign p   = {r_i, d_msb_i};
  assign s   = p - {1'b0, dvs_i};
  assign q_o = ~s[WIDTH];
  assign r_o = q_o ? s[WIDTH-1:0] : p[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider with start/busy/done handshake
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = cnt_w(WIDTH);
  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             negq_q, negq_d, negr_q, negr_d, dbz_q, dbz_d;
  logic             sgn, a_neg, b_neg, q_bit;
  logic [WIDTH-1:0] a_mag, b_mag, r_nx;
  assign sgn   = SIGNED_EN && signed_op;
  assign a_neg = sgn & dividend[WIDTH-1];
  assign b_neg = sgn & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i    (r_q),
    .d_msb_i(d_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .r_o    (r_nx),
    .q_o    (q_bit)
  );
  // next-state: accept in IDLE, iterate in RUN (quotient bits shift into d), sign-correct in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    d_d     = d_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        if (divisor == '0) begin
          state_d = DONE;
          quot_d  = {WIDTH{DBZ_QUOT_BIT}};
          rem_d   = dividend;
          dbz_d   = DBZ_FLAG;
        end else begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH - 1);
          r_d     = '0;
          d_d     = a_mag;
          dvs_d   = b_mag;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          quot_d  = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      RUN: begin
        r_d     = r_nx;
        d_d     = {d_q[WIDTH-2:0], q_bit};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? FIX : RUN;
      end
      FIX: begin
        quot_d  = negq_q ? -d_q : d_q;
        rem_d   = negr_q ? -r_q : r_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      d_q     <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (WIDTH=32)
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        clear, start, signed_op;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_by_zero;
  int          n_checks = 0;
  int          n_errors = 0;
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endtask
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez, input bit poke);
    int lat;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~s;
    check({tag, "_busy1"}, 32'(busy), 32'(b != 0));
    check({tag, "_qclr"}, quotient, (b == 0) ? 32'hFFFF_FFFF : 32'd0);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 5) begin
        start    = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd5;
      end else start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd1 : 32'd34);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    if (poke) begin
      start    = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd0;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done0"}, 32'(done), 32'd0);
    if (poke) begin
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, quotient, eq);
    end
  endtask
  initial begin
    logic [31:0] a, b, eq, er;
    logic        s, ez;
    clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    run_div("u100_7",   32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           1'b0, 1'b0);
    run_div("sm100_7",  32'hFFFF_FF9C,   32'd7,           1'b1, 32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0, 1'b0);
    run_div("s100_m7",  32'd100,         32'hFFFF_FFF9,   1'b1, 32'hFFFF_FFF2,   32'd2,           1'b0, 1'b0);
    run_div("sm100_m7", 32'hFFFF_FF9C,   32'hFFFF_FFF9,   1'b1, 32'd14,          32'hFFFF_FFFE,   1'b0, 1'b0);
    run_div("s_ovf",    32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0,           1'b0, 1'b0);
    run_div("u_big",    32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000,   1'b0, 1'b0);
    run_div("u_max16",  32'hFFFF_FFFF,   32'h10,          1'b0, 32'h0FFF_FFFF,   32'hF,           1'b0, 1'b0);
    run_div("dbz_u",    32'h1234,        32'd0,           1'b0, 32'hFFFF_FFFF,   32'h1234,        1'b1, 1'b0);
    run_div("u_after",  32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           1'b0, 1'b0);
    run_div("dbz_s",    32'hFFFF_FF00,   32'd0,           1'b1, 32'hFFFF_FFFF,   32'hFFFF_FF00,   1'b1, 1'b0);
    run_div("s7_100",   32'd7,           32'd100,         1'b1, 32'd0,           32'd7,           1'b0, 1'b0);
    run_div("poke",     32'd1000,        32'd10,          1'b0, 32'd100,         32'd0,           1'b0, 1'b1);
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    clear = 1'b1;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_q", quotient, 32'd0);
    check("clr_r", remainder, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    check("clr_hold", 32'(busy), 32'd0);
    run_div("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 5)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = -32'($urandom_range(1, 50));
        3: b = (i % 10 == 3) ? 32'd0 : 32'($urandom_range(1, 65535));
        default: b = 32'hFFFF_FFFF;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er, ez);
      run_div("rnd", a, b, s, eq, er, ez, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
